ysyx_24100006_pipe_ctrl: RTL and testbench
==========================================

Name: ysyx_24100006_pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It sits beside the IF/ID/EXE stages and produces their stall, bubble and flush controls. It detects load-use hazards between ID and EXE and squashes younger instructions on an EXE redirect. It also sequences fence.i: hold in EXE, drain memory, flush the icache, refetch.

Parameters:
FLUSH_TIMEOUT, 256, maximum cycles in WAIT_DONE before forced exit; 9-bit counter, range 1..511.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
id_valid  input  1  ID holds a valid instruction
id_rs1_addr  input  4  ID source register 1
id_rs2_addr  input  4  ID source register 2
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
exe_valid  input  1  EXE holds a valid instruction
exe_is_load  input  1  EXE instruction is a load
exe_gpr_write  input  1  EXE instruction writes a GPR
exe_rd  input  4  EXE destination register
exe_is_fence_i  input  1  EXE instruction is fence.i
exe_pc_add_4  input  32  EXE pc+4
redirect_valid  input  1  EXE branch/jump redirect
mem_idle  input  1  LSU has no outstanding bus transaction
icache_flush_done  input  1  icache invalidate complete (level)
stall_if  output  1  hold PC and IF/ID
stall_id  output  1  hold ID
bubble_exe  output  1  load NOP into ID/EXE
exe_hold  output  1  force exe_out_ready low
flush_if_id  output  1  invalidate IF/ID
flush_id_exe  output  1  invalidate ID/EXE
icache_flush_req  output  1  one-cycle icache invalidate pulse
fence_redirect  output  1  IFU refetch strobe
fence_redirect_pc  output  32  refetch target
flush_err  output  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at posedge): FSM to IDLE; timeout counter, fence_redirect_pc and flush_err cleared to 0. All registered outputs are 0; combinational outputs are 0 because state is IDLE and the inputs are masked.
- Load-use hazard (lu): id_valid & exe_valid & exe_is_load & exe_gpr_write & exe_rd!=0 & ((id_use_rs1 & rs1==exe_rd) | (id_use_rs2 & rs2==exe_rd)).
  - lu drives stall_if=stall_id=bubble_exe=1, combinationally, for exactly one cycle per occurrence.
- Redirect: redirect_valid & !exe_is_fence_i & state==IDLE drives flush_if_id=flush_id_exe=1 in the same cycle. It suppresses lu (stall/bubble=0) because the ID instruction is dead.
- FSM states: IDLE, DRAIN, FLUSH, WAIT_DONE, REFETCH. State is registered.
  - IDLE -> DRAIN: exe_valid & exe_is_fence_i. Latch fence_redirect_pc=exe_pc_add_4.
  - DRAIN -> FLUSH: mem_idle.
  - FLUSH -> WAIT_DONE: always, after 1 cycle. icache_flush_req=1 in FLUSH only.
  - WAIT_DONE -> REFETCH: icache_flush_done, or counter==FLUSH_TIMEOUT-1. On timeout, flush_err<=1.
    - The counter increments each WAIT_DONE cycle and clears on entry.
    - If done and timeout coincide, there is no error.
  - REFETCH -> IDLE: always. fence_redirect=flush_if_id=flush_id_exe=1 for this one cycle.
- exe_hold, stall_if and stall_id are 1 in every non-IDLE state.
  - Includes the IDLE cycle in which fence.i is detected (combinational), so the fence stays in EXE.
  - exe_hold=0 in REFETCH so the fence retires that cycle.
- In IDLE, fence detection has priority over lu and redirect. lu is masked whenever state!=IDLE.
- redirect_valid and exe_is_fence_i together is illegal; the fence wins.
- Latency: fence.i to fence_redirect = 4 + drain cycles + flush wait cycles minimum (icache_flush_done already high: 4 cycles).
- Reset mid-sequence aborts. icache_flush_req deasserts the next cycle; there is no refetch.

Optional Feature:
YSYX_24100006_PIPE_PERF_EN:
- Defined: adds 32-bit output counters perf_lu_stall (lu cycles), perf_redirect (redirect flushes) and perf_fence_cyc (non-IDLE cycles).
  - All cleared by reset; they saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: EXE load rd=5, ID use_rs2 rs2=5 -> stall_if/stall_id/bubble_exe=1 for 1 cycle. With rd=0 -> no stall.
- Redirect with lu: redirect_valid=1 and lu true -> flush_if_id=flush_id_exe=1, stall_if=0, bubble_exe=0.
- Fence.i: exe_pc_add_4=0x80000104, mem_idle=0 for 3 cycles, flush_done 2 cycles after req.
  - Required: one icache_flush_req pulse.
  - fence_redirect with pc 0x80000104 at cycle 1+3+1+2+1.
  - exe_hold high throughout until REFETCH.
- Timeout: FLUSH_TIMEOUT=4, flush_done=0 -> REFETCH after 4 WAIT_DONE cycles, flush_err=1 sticky until reset.
- Reset mid-WAIT_DONE: reset=0 one cycle -> state IDLE, all outputs 0, no fence_redirect afterwards.
- PERF_EN: 3 lu events and 2 redirects -> perf_lu_stall=3, perf_redirect=2.

Source files
------------

// File: rtl/ysyx_24100006_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100006_pipe_ctrl_if
// Description : Hazard/sequencing bus between the pipeline stages (master)
//               and the pipeline controller (slave). The perf counter
//               signals exist only when YSYX_24100006_PIPE_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_24100006_pipe_ctrl_if;
  // ID stage operands
  logic        id_valid;
  logic [3:0]  id_rs1_addr;
  logic [3:0]  id_rs2_addr;
  logic        id_use_rs1;
  logic        id_use_rs2;
  // EXE stage status
  logic        exe_valid;
  logic        exe_is_load;
  logic        exe_gpr_write;
  logic [3:0]  exe_rd;
  logic        exe_is_fence_i;
  logic [31:0] exe_pc_add_4;
  logic        redirect_valid;
  // Memory / icache status
  logic        mem_idle;
  logic        icache_flush_done;
  // Controls back to the pipeline
  logic        stall_if;
  logic        stall_id;
  logic        bubble_exe;
  logic        exe_hold;
  logic        flush_if_id;
  logic        flush_id_exe;
  logic        icache_flush_req;
  logic        fence_redirect;
  logic [31:0] fence_redirect_pc;
  logic        flush_err;
`ifdef YSYX_24100006_PIPE_PERF_EN
  logic [31:0] perf_lu_stall;
  logic [31:0] perf_redirect;
  logic [31:0] perf_fence_cyc;
`endif

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    output exe_valid, exe_is_load, exe_gpr_write, exe_rd, exe_is_fence_i,
    output exe_pc_add_4, redirect_valid, mem_idle, icache_flush_done,
    input  stall_if, stall_id, bubble_exe, exe_hold, flush_if_id, flush_id_exe,
`ifdef YSYX_24100006_PIPE_PERF_EN
    input  perf_lu_stall, perf_redirect, perf_fence_cyc,
`endif
    input  icache_flush_req, fence_redirect, fence_redirect_pc, flush_err
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
    input  exe_valid, exe_is_load, exe_gpr_write, exe_rd, exe_is_fence_i,
    input  exe_pc_add_4, redirect_valid, mem_idle, icache_flush_done,
    output stall_if, stall_id, bubble_exe, exe_hold, flush_if_id, flush_id_exe,
`ifdef YSYX_24100006_PIPE_PERF_EN
    output perf_lu_stall, perf_redirect, perf_fence_cyc,
`endif
    output icache_flush_req, fence_redirect, fence_redirect_pc, flush_err
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_24100006_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100006_pipe_ctrl
// Description : Hazard and sequencing controller for the 5-stage pipeline.
//               Detects ID/EXE load-use hazards, squashes younger work on an
//               EXE redirect and sequences fence.i (drain, icache flush,
//               refetch). Optional perf counters: YSYX_24100006_PIPE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100006_pipe_ctrl #(
  parameter int unsigned FLUSH_TIMEOUT = 256  // 1..511
) (
  input  logic                           clk,
  input  logic                           reset,  // synchronous, active-low
  ysyx_24100006_pipe_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_REFETCH   = 3'd4
  } state_t;

  localparam logic [8:0] C_CNT_LAST = 9'(FLUSH_TIMEOUT - 1);

  state_t      r_state;
  logic [8:0]  r_cnt;
  logic [31:0] r_pc;
  logic        r_err;
  logic        r_flush_req;
  logic        r_fence_redirect;

  logic w_run;
  logic w_idle;
  logic w_fence_det;
  logic w_redirect;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_lu;
  logic w_busy;
  logic w_refetch;

  // While reset is asserted every combinational control is masked to 0.
  assign w_run       = reset;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_fence_det = w_run & w_idle & bus.exe_valid & bus.exe_is_fence_i;
  // A redirect paired with fence.i is illegal; the fence takes precedence.
  assign w_redirect  = w_run & w_idle & bus.redirect_valid & ~bus.exe_is_fence_i;

  assign w_rs1_hit = bus.id_use_rs1 & (bus.id_rs1_addr == bus.exe_rd);
  assign w_rs2_hit = bus.id_use_rs2 & (bus.id_rs2_addr == bus.exe_rd);
  // Load-use only matters in IDLE and when ID is not being squashed.
  assign w_lu = w_run & w_idle & ~w_fence_det & ~w_redirect
              & bus.id_valid & bus.exe_valid & bus.exe_is_load & bus.exe_gpr_write
              & (bus.exe_rd != 4'd0) & (w_rs1_hit | w_rs2_hit);

  assign w_busy    = w_run & ~w_idle;
  assign w_refetch = w_run & (r_state == ST_REFETCH);

  assign bus.stall_if          = w_lu | w_fence_det | w_busy;
  assign bus.stall_id          = w_lu | w_fence_det | w_busy;
  assign bus.bubble_exe        = w_lu;
  // Fence stays in EXE until REFETCH, where it is allowed to retire.
  assign bus.exe_hold          = w_fence_det | (w_busy & ~w_refetch);
  assign bus.flush_if_id       = w_redirect | w_refetch;
  assign bus.flush_id_exe      = w_redirect | w_refetch;
  assign bus.icache_flush_req  = r_flush_req;
  assign bus.fence_redirect    = r_fence_redirect;
  assign bus.fence_redirect_pc = r_pc;
  assign bus.flush_err         = r_err;

  // fence.i sequencer with registered pulse outputs and timeout tracking.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_cnt            <= 9'd0;
      r_pc             <= 32'd0;
      r_err            <= 1'b0;
      r_flush_req      <= 1'b0;
      r_fence_redirect <= 1'b0;
    end else begin
      r_flush_req      <= 1'b0;
      r_fence_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fence_det) begin
            r_state <= ST_DRAIN;
            r_pc    <= bus.exe_pc_add_4;
          end
        end
        ST_DRAIN: begin
          if (bus.mem_idle) begin
            r_state     <= ST_FLUSH;
            r_flush_req <= 1'b1;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_WAIT_DONE;
          r_cnt   <= 9'd0;
        end
        ST_WAIT_DONE: begin
          r_cnt <= r_cnt + 9'd1;
          if (bus.icache_flush_done || (r_cnt == C_CNT_LAST)) begin
            r_state          <= ST_REFETCH;
            r_fence_redirect <= 1'b1;
            // A completion arriving on the last allowed cycle is not an error.
            if (!bus.icache_flush_done) begin
              r_err <= 1'b1;
            end
          end
        end
        ST_REFETCH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef YSYX_24100006_PIPE_PERF_EN
  logic [31:0] r_perf_lu;
  logic [31:0] r_perf_redirect;
  logic [31:0] r_perf_fence;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perf_lu       <= 32'd0;
      r_perf_redirect <= 32'd0;
      r_perf_fence    <= 32'd0;
    end else begin
      if (w_lu && (r_perf_lu != 32'hFFFF_FFFF)) begin
        r_perf_lu <= r_perf_lu + 32'd1;
      end
      if (w_redirect && (r_perf_redirect != 32'hFFFF_FFFF)) begin
        r_perf_redirect <= r_perf_redirect + 32'd1;
      end
      if (w_busy && (r_perf_fence != 32'hFFFF_FFFF)) begin
        r_perf_fence <= r_perf_fence + 32'd1;
      end
    end
  end

  assign bus.perf_lu_stall  = r_perf_lu;
  assign bus.perf_redirect  = r_perf_redirect;
  assign bus.perf_fence_cyc = r_perf_fence;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100006_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24100006_pipe_ctrl
// Description : Directed self-checking bench for ysyx_24100006_pipe_ctrl
//               (FLUSH_TIMEOUT=4 so the timeout path is short).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100006_pipe_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  ysyx_24100006_pipe_ctrl_if bus ();

  ysyx_24100006_pipe_ctrl #(.FLUSH_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.exe_valid = 0; bus.exe_is_load = 0; bus.exe_gpr_write = 0; bus.exe_rd = 0;
    bus.exe_is_fence_i = 0; bus.exe_pc_add_4 = 0; bus.redirect_valid = 0;
    bus.mem_idle = 1; bus.icache_flush_done = 0;
  endtask

  task automatic set_lu(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic u1, input logic u2);
    bus.id_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
    bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
    bus.exe_valid = 1; bus.exe_is_load = 1; bus.exe_gpr_write = 1; bus.exe_rd = rd;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_lu(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
    bus.redirect_valid = 1;
    reset = 0;
    #1;
    n_checks++;
    if ({bus.stall_if, bus.stall_id, bus.bubble_exe, bus.flush_if_id, bus.flush_id_exe} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_comb_mask: got %b want 00000",
               {bus.stall_if, bus.stall_id, bus.bubble_exe, bus.flush_if_id, bus.flush_id_exe});
    end
    tick();
    clear_inputs();
    reset = 1;
    #1;
    n_checks++;
    if ({bus.stall_if, bus.exe_hold, bus.icache_flush_req, bus.fence_redirect, bus.flush_err,
         bus.flush_if_id, bus.bubble_exe} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {bus.stall_if, bus.exe_hold, bus.icache_flush_req, bus.fence_redirect,
                bus.flush_err, bus.flush_if_id, bus.bubble_exe});
    end
    n_checks++;
    if (bus.fence_redirect_pc !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_pc: got %h want 00000000", bus.fence_redirect_pc);
    end
  endtask

  task automatic test_load_use();
    logic [3:0] rd_tab [5]  = '{4'd5, 4'd0, 4'd7, 4'd7, 4'd9};
    logic [3:0] rs1_tab [5] = '{4'd1, 4'd0, 4'd7, 4'd7, 4'd2};
    logic [3:0] rs2_tab [5] = '{4'd5, 4'd0, 4'd3, 4'd3, 4'd9};
    logic       u1_tab [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       u2_tab [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_tab [5] = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b000};
    for (int i = 0; i < 5; i++) begin
      tick();
      clear_inputs();
      set_lu(rd_tab[i], rs1_tab[i], rs2_tab[i], u1_tab[i], u2_tab[i]);
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.bubble_exe} !== exp_tab[i]) begin
        n_errors++;
        $display("FAIL load_use[%0d]: got %b want %b", i,
                 {bus.stall_if, bus.stall_id, bus.bubble_exe}, exp_tab[i]);
      end
    end
    // Bubble now sits in EXE: the hazard is gone.
    tick();
    bus.exe_is_load = 0; bus.exe_gpr_write = 0; bus.exe_valid = 0;
    #1;
    n_checks++;
    if ({bus.stall_if, bus.stall_id, bus.bubble_exe, bus.exe_hold} !== 4'b0) begin
      n_errors++;
      $display("FAIL load_use_release: got %b want 0000",
               {bus.stall_if, bus.stall_id, bus.bubble_exe, bus.exe_hold});
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_redirect();
    tick();
    clear_inputs();
    set_lu(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
    bus.redirect_valid = 1;
    #1;
    n_checks++;
    if ({bus.flush_if_id, bus.flush_id_exe, bus.stall_if, bus.stall_id, bus.bubble_exe,
         bus.exe_hold} !== 6'b110000) begin
      n_errors++;
      $display("FAIL redirect_lu: got %b want 110000",
               {bus.flush_if_id, bus.flush_id_exe, bus.stall_if, bus.stall_id,
                bus.bubble_exe, bus.exe_hold});
    end
    tick();
    clear_inputs();
    #1;
    n_checks++;
    if ({bus.flush_if_id, bus.flush_id_exe} !== 2'b00) begin
      n_errors++;
      $display("FAIL redirect_release: got %b want 00", {bus.flush_if_id, bus.flush_id_exe});
    end
  endtask

  // fence.i with 3 non-idle drain cycles and flush_done 2 cycles after req.
  task automatic test_fence();
    logic [4:0] got;
    logic [4:0] exp;
    int         n_req;
    n_req = 0;
    for (int c = 0; c <= 9; c++) begin
      tick();
      clear_inputs();
      bus.exe_valid = (c <= 8);
      bus.exe_is_fence_i = (c <= 8);
      bus.exe_pc_add_4 = 32'h8000_0104;
      bus.mem_idle = (c >= 4);
      bus.icache_flush_done = (c >= 7);
      #1;
      got = {bus.icache_flush_req, bus.fence_redirect, bus.exe_hold, bus.stall_if, bus.flush_if_id};
      exp = {c == 5, c == 8, c <= 7, c <= 8, c == 8};
      if (bus.icache_flush_req === 1'b1) n_req++;
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL fence_cycle[%0d] req/redir/hold/stall/flush: got %b want %b", c, got, exp);
      end
      if (c == 8) begin
        n_checks++;
        if (bus.fence_redirect_pc !== 32'h8000_0104) begin
          n_errors++;
          $display("FAIL fence_pc: got %h want 80000104", bus.fence_redirect_pc);
        end
      end
    end
    n_checks++;
    if (n_req != 1 || bus.flush_err !== 1'b0) begin
      n_errors++;
      $display("FAIL fence_req_count/err: got %0d/%b want 1/0", n_req, bus.flush_err);
    end
    tick();
    clear_inputs();
  endtask

  // Flush never completes (or completes exactly at the last allowed cycle).
  task automatic test_timeout(input bit coincide);
    logic [4:0] got;
    logic [4:0] exp;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      clear_inputs();
      bus.exe_valid = (c <= 7);
      bus.exe_is_fence_i = (c <= 7);
      bus.exe_pc_add_4 = 32'h0000_1000;
      bus.mem_idle = 1;
      bus.icache_flush_done = coincide && (c == 6);
      #1;
      got = {bus.icache_flush_req, bus.fence_redirect, bus.exe_hold, bus.flush_if_id, bus.flush_err};
      exp = {c == 2, c == 7, c <= 6, c == 7, !coincide && (c >= 7)};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL timeout%0d_cycle[%0d] req/redir/hold/flush/err: got %b want %b",
                 coincide, c, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_err_cleared();
    n_checks++;
    if (bus.flush_err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got %b want 1", bus.flush_err);
    end
    do_reset();
    #1;
    n_checks++;
    if (bus.flush_err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_cleared: got %b want 0", bus.flush_err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      clear_inputs();
      bus.exe_valid = (c <= 3);
      bus.exe_is_fence_i = (c <= 3);
      bus.exe_pc_add_4 = 32'h0000_2000;
      reset = (c != 4);
      #1;
      if (c >= 5) begin
        n_checks++;
        if ({bus.icache_flush_req, bus.fence_redirect, bus.exe_hold, bus.stall_if,
             bus.flush_if_id, bus.flush_err} !== 6'b0 || bus.fence_redirect_pc !== 32'd0) begin
          n_errors++;
          $display("FAIL reset_mid[%0d]: got %b pc %h want 000000 pc 00000000", c,
                   {bus.icache_flush_req, bus.fence_redirect, bus.exe_hold, bus.stall_if,
                    bus.flush_if_id, bus.flush_err}, bus.fence_redirect_pc);
        end
      end
      tick();
    end
    reset = 1;
  endtask

  task automatic test_back_to_back();
    // Consecutive hazards each stall; redirect squashes; hazard right after.
    logic [3:0] rd_tab [4]  = '{4'd3, 4'd4, 4'd4, 4'd6};
    logic       rv_tab [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] exp_tab [4] = '{5'b11100, 5'b11100, 5'b00011, 5'b11100};
    for (int i = 0; i < 4; i++) begin
      tick();
      clear_inputs();
      set_lu(rd_tab[i], rd_tab[i], 4'd0, 1'b1, 1'b0);
      bus.redirect_valid = rv_tab[i];
      #1;
      n_checks++;
      if ({bus.stall_if, bus.stall_id, bus.bubble_exe, bus.flush_if_id, bus.flush_id_exe}
          !== exp_tab[i]) begin
        n_errors++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i,
                 {bus.stall_if, bus.stall_id, bus.bubble_exe, bus.flush_if_id,
                  bus.flush_id_exe}, exp_tab[i]);
      end
    end
    tick();
    clear_inputs();
  endtask

`ifdef YSYX_24100006_PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clear_inputs();
      set_lu(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
      tick();
    end
    clear_inputs();
    bus.redirect_valid = 1;
    tick();
    set_lu(4'd5, 4'd0, 4'd5, 1'b0, 1'b1);
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (bus.perf_lu_stall !== 32'd3 || bus.perf_redirect !== 32'd2 || bus.perf_fence_cyc !== 32'd0) begin
      n_errors++;
      $display("FAIL perf: got lu=%0d redir=%0d fence=%0d want 3/2/0",
               bus.perf_lu_stall, bus.perf_redirect, bus.perf_fence_cyc);
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_fence();
    test_timeout(1'b0);
    test_err_cleared();
    test_timeout(1'b1);
    test_reset_mid();
    test_back_to_back();
`ifdef YSYX_24100006_PIPE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
